sram_ctrl: RTL and testbench

//   Synchronous initiator for the asynchronous 16-bit SRAM (active-low WE/OE, shared inout data bus).

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_data_pad.sv | 15 +
 rtl/sram_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM initiator: pin widths,
// default access length and the controller state encoding.
package sram_pkg;

  localparam int SRAM_ADDR_W      = 20;
  localparam int SRAM_DATA_W      = 16;
  localparam int SRAM_WAIT_CYCLES = 2;

  // Controller states. A read is a single OE-low phase; a write is split
  // into setup, WE-low pulse and hold so address/data bracket both WE edges.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    WR_SET   = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } sramState_e;

endpackage : sram_pkg

// File: rtl/sram_data_pad.sv
// Tristate buffer for the shared SRAM data bus. The controller drives the
// pad only while oe is high; din always reflects the resolved pad value.
module sram_data_pad #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] dout,
  input  logic              oe,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad = oe ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule : sram_data_pad

// File: rtl/sram_ctrl.sv
// Synchronous initiator for an asynchronous 16-bit SRAM. Turns single-beat
// valid/ready requests into SRAM pin timing with registered strobes,
// address and data, so WE and OE never overlap and the address/data are
// stable across every WE edge.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  // A zero-length strobe would violate the SRAM access time, so refuse to
  // build such a configuration at all.
  if (WAIT_CYCLES < 1) begin : gWaitCheck
    $error("sram_ctrl: WAIT_CYCLES must be at least 1");
  end

  // The counter holds WAIT_CYCLES-1 down to 0, one value per strobe-low clock.
  localparam int               CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  sramState_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              weN_q, weN_d;
  logic              oeN_q, oeN_d;
  logic              driveEn_q, driveEn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rspValid_q, rspValid_d;
  logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
  logic [DATA_W-1:0] padDin;
  logic              accept;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Bus pad: only the write phases (setup, pulse, hold) turn the driver on.
  sram_data_pad #(
    .DATA_W (DATA_W)
  ) uPad (
    .dout (wdata_q),
    .oe   (driveEn_q),
    .din  (padDin),
    .pad  (sram_data)
  );

  // State register; reset returns to IDLE regardless of any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: reads dwell in RD_ACC, writes walk setup/pulse/hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_we ? WR_SET : RD_ACC;
        end
      end
      RD_ACC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      WR_SET: begin
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: next values of every registered pin and the wait counter.
  // The address only changes on acceptance, so it is frozen whenever a
  // strobe is low; the drive enable drops one clock after WE rises.
  always_comb begin
    cnt_d      = cnt_q;
    weN_d      = weN_q;
    oeN_d      = oeN_q;
    driveEn_d  = driveEn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rspValid_d = 1'b0;
    rspRdata_d = rspRdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (req_we) begin
            wdata_d   = req_wdata;
            driveEn_d = 1'b1;
          end else begin
            oeN_d = 1'b0;
            cnt_d = CNT_LOAD;
          end
        end
      end
      RD_ACC: begin
        if (cnt_q == '0) begin
          rspRdata_d = padDin;
          rspValid_d = 1'b1;
          oeN_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_SET: begin
        weN_d = 1'b0;
        cnt_d = CNT_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          weN_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD: begin
        driveEn_d = 1'b0;
      end
      default: begin
        weN_d     = 1'b1;
        oeN_d     = 1'b1;
        driveEn_d = 1'b0;
      end
    endcase
  end

  // Pin and datapath registers; reset parks the bus with both strobes high
  // and the driver off, accepting that an interrupted write may be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      weN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      driveEn_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      weN_q      <= weN_d;
      oeN_q      <= oeN_d;
      driveEn_q  <= driveEn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
    end
  end

  assign sram_we_n = weN_q;
  assign sram_oe_n = oeN_q;
  assign sram_addr = addr_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;

  // Electrical safety properties of the SRAM interface.
  assert property (@(posedge clk) disable iff (!rst_n) !(!weN_q && !oeN_q));
  assert property (@(posedge clk) disable iff (!rst_n) !weN_q |-> driveEn_q);
  assert property (@(posedge clk) disable iff (!rst_n) !oeN_q |-> !driveEn_q);
  assert property (@(posedge clk) disable iff (!rst_n)
                   ($past(!weN_q || !oeN_q) && (!weN_q || !oeN_q)) |-> $stable(addr_q));

endmodule : sram_ctrl

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl with an asynchronous SRAM model on the pins and a
// word-level reference memory that predicts read data and timing.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int WAIT_CYCLES = 2;
  localparam int RD_LAT      = WAIT_CYCLES;
  localparam int WR_OCC      = WAIT_CYCLES + 2;
  localparam int RD_PERIOD   = WAIT_CYCLES + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_data;

  int checkCount;
  int errorCount;

  logic [DATA_W-1:0] refMem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] sramMem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  sram_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data)
  );

  // Asynchronous SRAM: drives the bus while OE is low, latches on WE rising.
  assign sram_data = (!sram_oe_n && sram_we_n) ? sramMem[sram_addr] : {DATA_W{1'bz}};

  always @(posedge sram_we_n) begin
    if (rst_n) sramMem[sram_addr] = sram_data;
  end

  // Pin-level safety monitor sampled mid-cycle.
  logic              prevValid = 1'b0;
  logic              prevStrobe;
  logic              prevOeN;
  logic              prevDrive;
  logic [ADDR_W-1:0] prevAddr;

  always @(negedge clk) begin
    if (rst_n) begin
      checkCount++;
      if (!sram_we_n && !sram_oe_n) begin
        errorCount++;
        $display("[TB] FAIL strobe_overlap: we_n=%b oe_n=%b, required not both low", sram_we_n, sram_oe_n);
      end
      if (!sram_we_n && !dut.driveEn_q) begin
        errorCount++;
        $display("[TB] FAIL drive_during_we: drive=%b, required 1 while we_n low", dut.driveEn_q);
      end
      if (!sram_oe_n && dut.driveEn_q) begin
        errorCount++;
        $display("[TB] FAIL drive_during_oe: drive=%b, required 0 while oe_n low", dut.driveEn_q);
      end
      if (prevValid && prevStrobe && (!sram_we_n || !sram_oe_n) && sram_addr !== prevAddr) begin
        errorCount++;
        $display("[TB] FAIL addr_stable: addr=%h, required %h while strobe low", sram_addr, prevAddr);
      end
      if (prevValid && prevOeN && !sram_oe_n && prevDrive) begin
        errorCount++;
        $display("[TB] FAIL turnaround: drive was on the clock before oe_n fell, required off");
      end
      prevValid  = 1'b1;
      prevStrobe = !sram_we_n || !sram_oe_n;
      prevOeN    = sram_oe_n;
      prevDrive  = dut.driveEn_q;
      prevAddr   = sram_addr;
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Bounded wait for the controller to become idle; expiry counts as a failure.
  task automatic waitIdle(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s_timeout: req_ready=%b after %0d clocks, required 1", tag, req_ready, n);
    end
  endtask

  // Issues one write and reports how many clocks the controller stayed busy.
  task automatic doWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input string tag, output int occ);
    waitIdle(tag);
    applyStimulus(1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    occ = 0;
    while (!req_ready && occ < 20) begin
      tick();
      occ++;
    end
    refMem[a] = d;
  endtask

  // Issues one read and reports the response latency and the returned word.
  task automatic doRead(input logic [ADDR_W-1:0] a, input string tag,
                        output int lat, output logic [DATA_W-1:0] got);
    waitIdle(tag);
    applyStimulus(1'b1, 1'b0, a, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = rsp_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (sram_we_n !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_we_n: got %b, required 1", sram_we_n); end
    checkCount++;
    if (sram_oe_n !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_oe_n: got %b, required 1", sram_oe_n); end
    checkCount++;
    if (sram_addr !== '0) begin errorCount++; $display("[TB] FAIL reset_addr: got %h, required 0", sram_addr); end
    checkCount++;
    if (rsp_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checkCount++;
    if (rsp_rdata !== '0) begin errorCount++; $display("[TB] FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
    checkCount++;
    if (dut.driveEn_q !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_drive: got %b, required 0", dut.driveEn_q); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkCount++;
    if (req_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_write_read();
    int occ, lat;
    logic [DATA_W-1:0] got;
    doWrite(20'h00005, 16'hBEEF, "wr_beef", occ);
    checkCount++;
    if (occ !== WR_OCC) begin errorCount++; $display("[TB] FAIL wr_occupancy: got %0d, required %0d", occ, WR_OCC); end
    doRead(20'h00005, "rd_beef", lat, got);
    checkCount++;
    if (lat !== RD_LAT) begin errorCount++; $display("[TB] FAIL rd_latency: got %0d, required %0d", lat, RD_LAT); end
    checkCount++;
    if (got !== refMem[20'h00005]) begin errorCount++; $display("[TB] FAIL rd_beef_data: got %h, required %h", got, refMem[20'h00005]); end
    tick();
    checkCount++;
    if (rsp_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL rsp_pulse_width: rsp_valid=%b, required 0", rsp_valid); end
    checkCount++;
    if (rsp_rdata !== refMem[20'h00005]) begin errorCount++; $display("[TB] FAIL rsp_hold: got %h, required %h", rsp_rdata, refMem[20'h00005]); end
  endtask

  task automatic test_addr_boundary();
    int occ, lat;
    logic [DATA_W-1:0] got;
    doWrite(20'hFFFFF, 16'h1234, "wr_top", occ);
    doWrite(20'h00000, 16'hA5A5, "wr_zero", occ);
    doRead(20'hFFFFF, "rd_top", lat, got);
    checkCount++;
    if (got !== refMem[20'hFFFFF]) begin errorCount++; $display("[TB] FAIL rd_top_data: got %h, required %h", got, refMem[20'hFFFFF]); end
    doRead(20'h00000, "rd_zero", lat, got);
    checkCount++;
    if (got !== refMem[20'h00000]) begin errorCount++; $display("[TB] FAIL rd_zero_data: got %h, required %h", got, refMem[20'h00000]); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] addrs [8];
    int occ, lat;
    logic [DATA_W-1:0] got;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = ADDR_W'($urandom());
      doWrite(addrs[i], DATA_W'($urandom()), "wr_rand", occ);
      checkCount++;
      if (occ !== WR_OCC) begin errorCount++; $display("[TB] FAIL rand_wr_occupancy: got %0d, required %0d", occ, WR_OCC); end
    end
    for (int i = 7; i >= 0; i--) begin
      doRead(addrs[i], "rd_rand", lat, got);
      checkCount++;
      if (got !== refMem[addrs[i]] || lat !== RD_LAT) begin
        errorCount++;
        $display("[TB] FAIL rand_read @%h: got %h lat %0d, required %h lat %0d", addrs[i], got, lat, refMem[addrs[i]], RD_LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    int acceptCyc [$];
    logic [DATA_W-1:0] gotQ [$];
    int occ, cyc, idx, stalls;
    logic readyBefore;
    for (int i = 0; i < 4; i++) begin
      addrs[i] = ADDR_W'($urandom());
      doWrite(addrs[i], DATA_W'($urandom()), "wr_b2b", occ);
    end
    waitIdle("b2b_start");
    cyc = 0;
    idx = 0;
    stalls = 0;
    applyStimulus(1'b1, 1'b0, addrs[0], '0);
    while ((idx < 4 || gotQ.size() < 4) && cyc < 60) begin
      readyBefore = req_ready;
      if (idx < 4 && !readyBefore) stalls++;
      tick();
      cyc++;
      if (readyBefore && idx < 4) begin
        acceptCyc.push_back(cyc);
        idx++;
        if (idx < 4) req_addr = addrs[idx];
        else applyStimulus(1'b0, 1'b0, '0, '0);
      end
      if (rsp_valid) gotQ.push_back(rsp_rdata);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkCount++;
    if (gotQ.size() !== 4 || acceptCyc.size() !== 4) begin
      errorCount++;
      $display("[TB] FAIL b2b_counts: accepts %0d responses %0d, required 4 and 4", acceptCyc.size(), gotQ.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checkCount++;
        if (acceptCyc[i] - acceptCyc[i-1] !== RD_PERIOD) begin
          errorCount++;
          $display("[TB] FAIL b2b_spacing[%0d]: got %0d clocks, required %0d", i, acceptCyc[i] - acceptCyc[i-1], RD_PERIOD);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checkCount++;
        if (gotQ[i] !== refMem[addrs[i]]) begin
          errorCount++;
          $display("[TB] FAIL b2b_data[%0d]: got %h, required %h", i, gotQ[i], refMem[addrs[i]]);
        end
      end
    end
    checkCount++;
    if (stalls !== 3 * (RD_PERIOD - 1)) begin
      errorCount++;
      $display("[TB] FAIL b2b_ready_low: got %0d stalled clocks, required %0d", stalls, 3 * (RD_PERIOD - 1));
    end
  endtask

  task automatic test_turnaround();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, got;
    int occ, lat;
    a = ADDR_W'($urandom());
    d = DATA_W'($urandom());
    doWrite(a, d, "wr_turn", occ);
    checkCount++;
    if (dut.driveEn_q !== 1'b0 || sram_oe_n !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL turn_gap: drive=%b oe_n=%b before read accept, required 0 and 1", dut.driveEn_q, sram_oe_n);
    end
    doRead(a, "rd_turn", lat, got);
    checkCount++;
    if (got !== refMem[a]) begin errorCount++; $display("[TB] FAIL turn_data: got %h, required %h", got, refMem[a]); end
  endtask

  task automatic test_busy_ignore();
    logic [ADDR_W-1:0] a, b;
    logic [DATA_W-1:0] v1, vb, got;
    int occ, lat, strobes;
    a  = ADDR_W'($urandom());
    b  = a ^ 20'h00001;
    v1 = DATA_W'($urandom());
    vb = ~v1;
    doWrite(a, v1, "wr_busy_a", occ);
    waitIdle("busy_start");
    applyStimulus(1'b1, 1'b1, b, vb);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    refMem[b] = vb;
    applyStimulus(1'b1, 1'b1, a, ~v1);
    checkCount++;
    if (req_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL busy_ready: got %b, required 0", req_ready); end
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitIdle("busy_end");
    strobes = 0;
    repeat (4) begin
      tick();
      if (!sram_we_n || !sram_oe_n) strobes++;
    end
    checkCount++;
    if (strobes !== 0) begin errorCount++; $display("[TB] FAIL busy_extra_access: got %0d strobe clocks, required 0", strobes); end
    doRead(a, "rd_busy_a", lat, got);
    checkCount++;
    if (got !== refMem[a]) begin errorCount++; $display("[TB] FAIL busy_a_unchanged: got %h, required %h", got, refMem[a]); end
    doRead(b, "rd_busy_b", lat, got);
    checkCount++;
    if (got !== refMem[b]) begin errorCount++; $display("[TB] FAIL busy_b_data: got %h, required %h", got, refMem[b]); end
  endtask

  task automatic test_reset_during_write();
    logic [ADDR_W-1:0] a, c;
    logic [DATA_W-1:0] got;
    int occ, lat;
    a = 20'h0ABCD;
    c = 20'h0ABCE;
    waitIdle("rstw_start");
    applyStimulus(1'b1, 1'b1, a, 16'h5A5A);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    tick();
    checkCount++;
    if (sram_we_n !== 1'b0) begin errorCount++; $display("[TB] FAIL rstw_pulse_entry: we_n=%b, required 0", sram_we_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (sram_we_n !== 1'b1) begin errorCount++; $display("[TB] FAIL rstw_we_n: got %b, required 1", sram_we_n); end
    checkCount++;
    if (sram_oe_n !== 1'b1) begin errorCount++; $display("[TB] FAIL rstw_oe_n: got %b, required 1", sram_oe_n); end
    checkCount++;
    if (dut.driveEn_q !== 1'b0) begin errorCount++; $display("[TB] FAIL rstw_drive: got %b, required 0", dut.driveEn_q); end
    checkCount++;
    if (rsp_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL rstw_rsp_valid: got %b, required 0", rsp_valid); end
    refMem.delete(a);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkCount++;
    if (req_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL rstw_ready: got %b, required 1", req_ready); end
    doWrite(c, 16'h0F0F, "wr_after_rst", occ);
    doRead(c, "rd_after_rst", lat, got);
    checkCount++;
    if (got !== refMem[c]) begin errorCount++; $display("[TB] FAIL rstw_recover: got %h, required %h", got, refMem[c]); end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    $display("[TB] starting sram_ctrl bench, WAIT_CYCLES=%0d", WAIT_CYCLES);
    test_reset();
    test_write_read();
    test_addr_boundary();
    test_random();
    test_back_to_back();
    test_turnaround();
    test_busy_ignore();
    test_reset_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule : tb_sram_ctrl
